// File: rtl/crossbar_pkg.sv
// Shared types for the crossbar route-table controller: FSM state encoding and
// the route-table entry layout used by both the shadow and the active table.
package crossbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Entries carry a fixed-width source index so the struct can live here;
    // this bounds the design at 256 inputs.
    localparam int ROUTE_SRC_W = 8;

    typedef struct packed {
        logic [ROUTE_SRC_W-1:0] src;
        logic                   en;
    } route_entry_t;

    function automatic route_entry_t reset_entry(input int j, input int n_in);
        route_entry_t e;
        e.src = ROUTE_SRC_W'(j % n_in);
        e.en  = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/crossbar_route_ctrl_route_decoder.sv
// Index-to-one-hot decoder for one crossbar output; a disabled entry or an index
// beyond the input count decodes to all zeros.
module route_decoder
    import crossbar_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  route_entry_t    i_entry,
    output logic [N_IN-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < N_IN; i++) begin
            o_onehot[i] = i_entry.en && (i_entry.src == ROUTE_SRC_W'(i));
        end
    end

endmodule

// File: rtl/crossbar_route_ctrl.sv
// Double-buffered crossbar route table: entries are written to a shadow table, a
// commit scans it for input collisions and then copies it atomically to the active table.
//
// Handshake: a shadow write is accepted on a rising edge where cfg_valid && cfg_ready;
// cfg_ready is high only while the FSM is idle, so the table cannot change under a scan.
module crossbar_route_ctrl
    import crossbar_pkg::*;
#(
    parameter int N_IN            = 8,
    parameter int N_OUT           = 8,
    parameter int ALLOW_MULTICAST = 0,
    parameter int SRC_BITS        = $clog2(N_IN),
    parameter int DST_BITS        = $clog2(N_OUT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [DST_BITS-1:0] cfg_dst,
    input  logic [SRC_BITS-1:0] cfg_src,
    input  logic                cfg_en,
    output logic                cfg_err,
    input  logic                commit_req,
    output logic                busy,
    output logic                commit_done,
    output logic                commit_err,
    output logic [DST_BITS-1:0] collide_dst,
    output logic [N_OUT-1:0]    out_en,
    output logic [N_IN-1:0]     select_SE [N_OUT],
    output state_t              dbg_state
);

    localparam int                  CLAIM_W   = 1 << SRC_BITS;
    localparam logic [DST_BITS-1:0] LAST_DST  = DST_BITS'(N_OUT - 1);
    localparam logic [DST_BITS:0]   DST_LIMIT = (DST_BITS + 1)'(N_OUT);
    localparam logic [SRC_BITS:0]   SRC_LIMIT = (SRC_BITS + 1)'(N_IN);

    state_t              r_state, w_state_next;
    logic [DST_BITS-1:0] r_k, w_k_next;
    logic [CLAIM_W-1:0]  r_claimed, w_claimed_next;
    route_entry_t        r_shadow [N_OUT];
    route_entry_t        r_active [N_OUT];
    route_entry_t        w_dec_in [N_OUT];
    route_entry_t        w_cur;
    logic [SRC_BITS-1:0] w_cur_src;
    logic [N_IN-1:0]     r_select  [N_OUT];
    logic [N_IN-1:0]     w_dec_sel [N_OUT];
    logic                w_cfg_fire, w_cfg_bad, w_collide;
    logic                r_cfg_err, r_commit_done, r_commit_err;
    logic [DST_BITS-1:0] r_collide_dst;

    assign w_cfg_fire = cfg_valid && (r_state == ST_IDLE);
    assign w_cfg_bad  = ({1'b0, cfg_dst} >= DST_LIMIT) || ({1'b0, cfg_src} >= SRC_LIMIT);
    assign w_cur      = r_shadow[r_k];
    assign w_cur_src  = w_cur.src[SRC_BITS-1:0];

    always_comb begin
        w_state_next   = r_state;
        w_k_next       = r_k;
        w_claimed_next = r_claimed;
        w_collide      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (commit_req) begin
                    w_state_next   = ST_CHECK;
                    w_k_next       = '0;
                    w_claimed_next = '0;
                end
            end
            ST_CHECK: begin
                if (ALLOW_MULTICAST != 0) begin
                    w_state_next = ST_APPLY;
                end else if (w_cur.en && r_claimed[w_cur_src]) begin
                    w_state_next = ST_IDLE;
                    w_collide    = 1'b1;
                end else begin
                    w_claimed_next[w_cur_src] = r_claimed[w_cur_src] | w_cur.en;
                    if (r_k == LAST_DST) begin
                        w_state_next = ST_APPLY;
                    end else begin
                        w_k_next = r_k + 1'b1;
                    end
                end
            end
            ST_APPLY: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // During APPLY the decoders look at the shadow entries so the select registers
    // change on the same edge that copies shadow into active; otherwise they re-decode active.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_dec_in[j] = (r_state == ST_APPLY) ? r_shadow[j] : r_active[j];
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_dec
        route_decoder #(.N_IN(N_IN)) u_dec (
            .i_entry  (w_dec_in[j]),
            .o_onehot (w_dec_sel[j])
        );
        assign out_en[j] = r_active[j].en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_k           <= '0;
            r_claimed     <= '0;
            r_cfg_err     <= 1'b0;
            r_commit_done <= 1'b0;
            r_commit_err  <= 1'b0;
            r_collide_dst <= '0;
        end else begin
            r_state       <= w_state_next;
            r_k           <= w_k_next;
            r_claimed     <= w_claimed_next;
            r_cfg_err     <= w_cfg_fire && w_cfg_bad;
            r_commit_done <= (r_state == ST_APPLY);
            r_commit_err  <= w_collide;
            if (w_collide) begin
                r_collide_dst <= r_k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                r_shadow[j] <= reset_entry(j, N_IN);
                r_active[j] <= reset_entry(j, N_IN);
                r_select[j] <= '0;
            end
        end else begin
            if (w_cfg_fire && !w_cfg_bad) begin
                r_shadow[cfg_dst] <= '{src: ROUTE_SRC_W'(cfg_src), en: cfg_en};
            end
            if (r_state == ST_APPLY) begin
                r_active <= r_shadow;
            end
            for (int j = 0; j < N_OUT; j++) begin
                r_select[j] <= w_dec_sel[j];
            end
        end
    end

    assign cfg_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign cfg_err     = r_cfg_err;
    assign commit_done = r_commit_done;
    assign commit_err  = r_commit_err;
    assign collide_dst = r_collide_dst;
    assign select_SE   = r_select;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_crossbar_route_ctrl.sv
// Self-checking bench for crossbar_route_ctrl: unicast 8x8, multicast 8x8 and a
// 6-input instance share one clock and reset.
module tb_crossbar_route_ctrl;
    import crossbar_pkg::*;

    localparam int NI = 8;
    localparam int NO = 8;
    localparam int W  = NO + NI * NO;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q [$];

    // unicast instance
    logic          a_cfg_valid, a_cfg_ready, a_cfg_en, a_cfg_err, a_commit_req;
    logic          a_busy, a_done, a_err;
    logic [2:0]    a_cfg_dst, a_cfg_src, a_collide;
    logic [NO-1:0] a_out_en;
    logic [NI-1:0] a_sel [NO];
    state_t        a_state;

    // multicast instance
    logic          m_cfg_valid, m_cfg_ready, m_cfg_en, m_cfg_err, m_commit_req;
    logic          m_busy, m_done, m_err;
    logic [2:0]    m_cfg_dst, m_cfg_src, m_collide;
    logic [NO-1:0] m_out_en;
    logic [NI-1:0] m_sel [NO];
    state_t        m_state;

    // six-input instance
    logic          c_cfg_valid, c_cfg_ready, c_cfg_en, c_cfg_err, c_commit_req;
    logic          c_busy, c_done, c_err;
    logic [2:0]    c_cfg_dst, c_cfg_src, c_collide;
    logic [NO-1:0] c_out_en;
    logic [5:0]    c_sel [NO];
    state_t        c_state;

    crossbar_route_ctrl #(.N_IN(NI), .N_OUT(NO), .ALLOW_MULTICAST(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_dst(a_cfg_dst), .cfg_src(a_cfg_src), .cfg_en(a_cfg_en), .cfg_err(a_cfg_err),
        .commit_req(a_commit_req), .busy(a_busy), .commit_done(a_done), .commit_err(a_err),
        .collide_dst(a_collide), .out_en(a_out_en), .select_SE(a_sel), .dbg_state(a_state)
    );

    crossbar_route_ctrl #(.N_IN(NI), .N_OUT(NO), .ALLOW_MULTICAST(1)) u_mc (
        .clk(clk), .rst_n(rst_n), .cfg_valid(m_cfg_valid), .cfg_ready(m_cfg_ready),
        .cfg_dst(m_cfg_dst), .cfg_src(m_cfg_src), .cfg_en(m_cfg_en), .cfg_err(m_cfg_err),
        .commit_req(m_commit_req), .busy(m_busy), .commit_done(m_done), .commit_err(m_err),
        .collide_dst(m_collide), .out_en(m_out_en), .select_SE(m_sel), .dbg_state(m_state)
    );

    crossbar_route_ctrl #(.N_IN(6), .N_OUT(NO), .ALLOW_MULTICAST(0)) u_r6 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(c_cfg_valid), .cfg_ready(c_cfg_ready),
        .cfg_dst(c_cfg_dst), .cfg_src(c_cfg_src), .cfg_en(c_cfg_en), .cfg_err(c_cfg_err),
        .commit_req(c_commit_req), .busy(c_busy), .commit_done(c_done), .commit_err(c_err),
        .collide_dst(c_collide), .out_en(c_out_en), .select_SE(c_sel), .dbg_state(c_state)
    );

    // reference model of the unicast instance
    int           md_route [NO];
    bit           md_en    [NO];
    logic [W-1:0] md_active;

    function automatic logic [W-1:0] model_view();
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < NO; j++) begin
            v[NO*NI + j] = md_en[j];
            if (md_en[j]) v[j*NI + md_route[j]] = 1'b1;
        end
        return v;
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < NO; j++) begin
            md_route[j] = j % NI;
            md_en[j]    = 1'b0;
        end
        md_active = '0;
    endfunction

    function automatic logic [W-1:0] a_view();
        logic [W-1:0] v;
        for (int j = 0; j < NO; j++) begin
            v[j*NI +: NI] = a_sel[j];
            v[NO*NI + j]  = a_out_en[j];
        end
        return v;
    endfunction

    function automatic logic [W-1:0] m_view();
        logic [W-1:0] v;
        for (int j = 0; j < NO; j++) begin
            v[j*NI +: NI] = m_sel[j];
            v[NO*NI + j]  = m_out_en[j];
        end
        return v;
    endfunction

    task automatic a_wr(input int d, input int s, input bit e);
        @(negedge clk);
        a_cfg_valid = 1'b1;
        a_cfg_dst   = 3'(d);
        a_cfg_src   = 3'(s);
        a_cfg_en    = e;
        md_route[d] = s;
        md_en[d]    = e;
        @(negedge clk);
        a_cfg_valid = 1'b0;
        total++;
        if (a_cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL wr_cfg_err: dst=%0d got=%0b required=0", d, a_cfg_err);
        end
    endtask

    task automatic a_commit(input bit exp_ok, input int exp_lat, input int exp_cd,
                            input bit do_wr, input int wd, input int ws, input bit we);
        logic [W-1:0] prev, got, exp;
        int n;
        bit glitch;
        prev = md_active;
        if (do_wr) begin
            md_route[wd] = ws;
            md_en[wd]    = we;
        end
        if (exp_ok) md_active = model_view();
        exp_q.push_back(md_active);
        @(negedge clk);
        a_commit_req = 1'b1;
        if (do_wr) begin
            a_cfg_valid = 1'b1;
            a_cfg_dst   = 3'(wd);
            a_cfg_src   = 3'(ws);
            a_cfg_en    = we;
        end
        @(negedge clk);
        a_commit_req = 1'b0;
        a_cfg_valid  = 1'b0;
        total++;
        if (a_busy !== 1'b1 || a_cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL commit_busy: busy=%0b cfg_ready=%0b required busy=1 cfg_ready=0",
                     a_busy, a_cfg_ready);
        end
        n = 0;
        glitch = 1'b0;
        while (a_done !== 1'b1 && a_err !== 1'b1 && n < 40) begin
            if (a_view() !== prev) glitch = 1'b1;
            @(negedge clk);
            n++;
        end
        total++;
        if (glitch) begin
            bad++;
            $display("FAIL select_glitch: select changed before the commit finished");
        end
        total++;
        if (n !== exp_lat) begin
            bad++;
            $display("FAIL commit_latency: got=%0d required=%0d", n, exp_lat);
        end
        total++;
        if (a_done !== exp_ok || a_err !== !exp_ok) begin
            bad++;
            $display("FAIL commit_outcome: done=%0b err=%0b required done=%0b", a_done, a_err, exp_ok);
        end
        if (!exp_ok) begin
            total++;
            if (a_collide !== 3'(exp_cd)) begin
                bad++;
                $display("FAIL collide_dst: got=%0d required=%0d", a_collide, exp_cd);
            end
        end
        exp = exp_q.pop_front();
        got = a_view();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL table_view: got=%h required=%h", got, exp);
        end
        @(negedge clk);
        total++;
        if (a_done !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width: done=%0b err=%0b busy=%0b required all 0", a_done, a_err, a_busy);
        end
    endtask

    task automatic test_reset();
        total++;
        if (a_view() !== '0 || m_view() !== '0 || c_out_en !== '0) begin
            bad++;
            $display("FAIL reset_tables: a=%h m=%h c_en=%h required 0", a_view(), m_view(), c_out_en);
        end
        total++;
        if (a_busy !== 1'b0 || a_cfg_ready !== 1'b1 || a_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_fsm: busy=%0b ready=%0b state=%0d required 0/1/IDLE",
                     a_busy, a_cfg_ready, a_state);
        end
        total++;
        if (a_done !== 1'b0 || a_err !== 1'b0 || a_cfg_err !== 1'b0 || a_collide !== 3'd0) begin
            bad++;
            $display("FAIL reset_flags: done=%0b err=%0b cfg_err=%0b collide=%0d required 0",
                     a_done, a_err, a_cfg_err, a_collide);
        end
    endtask

    task automatic test_identity();
        logic [NI-1:0] one;
        bit sel_bad;
        for (int j = 0; j < NO; j++) a_wr(j, j, 1'b1);
        a_commit(1'b1, NO + 1, 0, 1'b0, 0, 0, 1'b0);
        total++;
        if (a_out_en !== 8'hFF) begin
            bad++;
            $display("FAIL identity_out_en: got=%h required=ff", a_out_en);
        end
        sel_bad = 1'b0;
        for (int j = 0; j < NO; j++) begin
            one = 8'd1;
            if (a_sel[j] !== (one << j)) sel_bad = 1'b1;
        end
        total++;
        if (sel_bad) begin
            bad++;
            $display("FAIL identity_select: got=%h required one-hot diagonal", a_view());
        end
    endtask

    task automatic test_collision();
        int tbl [NO] = '{3, 1, 7, 0, 2, 6, 3, 4};
        for (int j = 0; j < NO; j++) a_wr(j, tbl[j], 1'b1);
        a_commit(1'b0, 7, 6, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_write_with_commit();
        a_commit(1'b1, NO + 1, 0, 1'b1, 6, 3, 1'b0);
        total++;
        if (a_out_en !== 8'hBF || a_sel[0] !== 8'b00001000 || a_sel[6] !== 8'h00) begin
            bad++;
            $display("FAIL disabled_out: out_en=%h sel0=%b sel6=%b required bf/00001000/0",
                     a_out_en, a_sel[0], a_sel[6]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        int n;
        bit extra;
        a_wr(5, 5, 1'b1);
        md_active = model_view();
        exp_q.push_back(md_active);
        @(negedge clk);
        a_commit_req = 1'b1;
        @(negedge clk);
        total++;
        if (a_busy !== 1'b1 || a_cfg_ready !== 1'b0 || a_state !== ST_CHECK) begin
            bad++;
            $display("FAIL busy_handshake: busy=%0b ready=%0b state=%0d required 1/0/CHECK",
                     a_busy, a_cfg_ready, a_state);
        end
        a_cfg_valid = 1'b1;
        a_cfg_dst   = 3'd0;
        a_cfg_src   = 3'd5;
        a_cfg_en    = 1'b1;
        @(negedge clk);
        a_commit_req = 1'b0;
        a_cfg_valid  = 1'b0;
        n = 1;
        while (a_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== NO + 1) begin
            bad++;
            $display("FAIL busy_latency: got=%0d required=%0d", n, NO + 1);
        end
        exp = exp_q.pop_front();
        total++;
        if (a_view() !== exp) begin
            bad++;
            $display("FAIL busy_ignored_write: got=%h required=%h", a_view(), exp);
        end
        extra = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a_done !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0) extra = 1'b1;
        end
        total++;
        if (extra) begin
            bad++;
            $display("FAIL busy_no_queue: a second commit ran, required none");
        end
    endtask

    task automatic test_multicast();
        logic [W-1:0] exp;
        int n;
        for (int j = 0; j < NO; j++) begin
            @(negedge clk);
            m_cfg_valid = 1'b1;
            m_cfg_dst   = 3'(j);
            m_cfg_src   = 3'd0;
            m_cfg_en    = 1'b1;
        end
        @(negedge clk);
        m_cfg_valid = 1'b0;
        exp = '0;
        for (int j = 0; j < NO; j++) begin
            exp[j*NI]     = 1'b1;
            exp[NO*NI + j] = 1'b1;
        end
        exp_q.push_back(exp);
        m_commit_req = 1'b1;
        @(negedge clk);
        m_commit_req = 1'b0;
        n = 0;
        while (m_done !== 1'b1 && m_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 2 || m_done !== 1'b1) begin
            bad++;
            $display("FAIL mc_latency: got=%0d done=%0b required=2 done=1", n, m_done);
        end
        exp = exp_q.pop_front();
        total++;
        if (m_view() !== exp) begin
            bad++;
            $display("FAIL mc_view: got=%h required=%h", m_view(), exp);
        end
    endtask

    task automatic test_range_handshake();
        int n;
        bit others;
        @(negedge clk);
        c_cfg_valid = 1'b1;
        c_cfg_dst   = 3'd2;
        c_cfg_src   = 3'd4;
        c_cfg_en    = 1'b1;
        @(negedge clk);
        c_cfg_src = 3'd7;
        total++;
        if (c_cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL r6_good_write: cfg_err=%0b required=0", c_cfg_err);
        end
        @(negedge clk);
        c_cfg_valid = 1'b0;
        total++;
        if (c_cfg_err !== 1'b1) begin
            bad++;
            $display("FAIL r6_range_err: cfg_err=%0b required=1", c_cfg_err);
        end
        c_commit_req = 1'b1;
        @(negedge clk);
        c_commit_req = 1'b0;
        total++;
        if (c_cfg_err !== 1'b0 || c_busy !== 1'b1 || c_cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL r6_pulse_busy: cfg_err=%0b busy=%0b ready=%0b required 0/1/0",
                     c_cfg_err, c_busy, c_cfg_ready);
        end
        n = 0;
        while (c_done !== 1'b1 && c_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== NO + 1 || c_done !== 1'b1) begin
            bad++;
            $display("FAIL r6_commit: latency=%0d done=%0b required=%0d done=1", n, c_done, NO + 1);
        end
        others = 1'b0;
        for (int j = 0; j < NO; j++) if (j != 2 && c_sel[j] !== 6'd0) others = 1'b1;
        total++;
        if (c_sel[2] !== 6'b010000 || others || c_out_en !== 8'h04) begin
            bad++;
            $display("FAIL r6_shadow_kept: sel2=%b out_en=%h required 010000/04", c_sel[2], c_out_en);
        end
    endtask

    task automatic test_reset_mid_commit();
        @(negedge clk);
        a_commit_req = 1'b1;
        @(negedge clk);
        a_commit_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (a_view() !== '0 || a_busy !== 1'b0 || a_state !== ST_IDLE || a_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: view=%h busy=%0b state=%0d required 0/0/IDLE",
                     a_view(), a_busy, a_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        a_commit(1'b1, NO + 1, 0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        a_cfg_valid = 0; a_cfg_dst = 0; a_cfg_src = 0; a_cfg_en = 0; a_commit_req = 0;
        m_cfg_valid = 0; m_cfg_dst = 0; m_cfg_src = 0; m_cfg_en = 0; m_commit_req = 0;
        c_cfg_valid = 0; c_cfg_dst = 0; c_cfg_src = 0; c_cfg_en = 0; c_commit_req = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_identity();
        test_collision();
        test_write_with_commit();
        test_back_to_back();
        test_multicast();
        test_range_handshake();
        test_reset_mid_commit();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crossbar_route_ctrl.md
Name: crossbar_route_ctrl

Overview:
Registered, double-buffered route-table controller for the NxM crossbar; successor to the combinational route-to-one-hot decoder.
- Route entries are written one at a time into a shadow table.
- A commit scans the shadow table for input collisions, one output per cycle.
- A clean scan is atomically applied to the active table, which drives registered one-hot select lines to the switch elements.
- Parametrised in input/output count and adds a multicast mode, per-output enable and error reporting.

Parameters:
N_IN, 8, number of crossbar inputs (>=2)
N_OUT, 8, number of crossbar outputs (>=2)
ALLOW_MULTICAST, 0, 1 = several outputs may select the same input (collision scan skipped); 0 = such a table is a collision
SRC_BITS, $clog2(N_IN), width of a route index (derived, not overridden)
DST_BITS, $clog2(N_OUT), width of an output index (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  shadow-table write request
cfg_ready  out  1  high only in IDLE; a write is accepted when cfg_valid && cfg_ready
cfg_dst  in  DST_BITS  output index to write
cfg_src  in  SRC_BITS  input index selected by that output
cfg_en  in  1  output enable for that entry
cfg_err  out  1  one-cycle pulse: accepted write dropped because it was out of range
commit_req  in  1  pulse; starts a commit from IDLE, ignored otherwise
busy  out  1  high in CHECK and APPLY
commit_done  out  1  one-cycle pulse when the active table has been updated
commit_err  out  1  one-cycle pulse when a commit aborts on a collision
collide_dst  out  DST_BITS  output index where the collision was found; held until the next commit_err
out_en  out  N_OUT  registered active enable per output
select_SE  out  N_IN x N_OUT  registered, unpacked per output; select_SE[j] is one-hot at bit route[j] when out_en[j]=1, else all zero

Behaviour:
Reset (asynchronous, rst_n=0):
- FSM = IDLE.
- Shadow table: route[j] = j mod N_IN, en[j] = 0.
- Active table: identical to the shadow table.
- Outputs: select_SE all 0, out_en = 0, cfg_err/commit_done/commit_err = 0, collide_dst = 0, busy = 0.

Shadow writes:
- Performed in IDLE only.
- Write lands on the next edge.
- If cfg_dst >= N_OUT or cfg_src >= N_IN: the write is dropped and cfg_err pulses on the next cycle.

FSM states: IDLE -> CHECK -> APPLY -> IDLE, with abort CHECK -> IDLE.
IDLE:
- commit_req=1 -> CHECK; scan index k = 0, claimed mask = 0.
- If a cfg write and commit_req arrive in the same cycle, the write is included in the commit.
CHECK:
- One output per cycle, k = 0..N_OUT-1.
- If en[k] && claimed[route[k]] && !ALLOW_MULTICAST: go to IDLE, pulse commit_err, load collide_dst = k. The active table is untouched.
- Otherwise: claimed[route[k]] |= en[k]; if k = N_OUT-1 go to APPLY, else k++.
- If ALLOW_MULTICAST=1: CHECK lasts one cycle and goes directly to APPLY.
APPLY:
- Active table <= shadow; select_SE/out_en updated at this edge.
- commit_done pulses in the same cycle as the new select values.
- Next state is IDLE.

Latency:
- ALLOW_MULTICAST=0, commit_req at cycle t: new select_SE visible at t+N_OUT+2.
- ALLOW_MULTICAST=1: visible at t+3.

Boundary conditions:
- select_SE never glitches mid-commit; it changes only at the APPLY edge or on reset.
- Disabled outputs never claim an input and never collide.
- Reset asserted mid-commit: the commit is abandoned and both tables return to reset values.
- commit_req while busy: ignored, with no queueing.
- Collision scan order is ascending output index; collide_dst reports the higher-indexed output of the colliding pair.

Decomposition:
- Package crossbar_pkg: state enum (IDLE, CHECK, APPLY) and a route_entry_t struct {src, en}, parameterised via localparams or with widths passed explicitly.
- One natural sub-module: route_decoder. It is the combinational index-to-one-hot decoder with enable, instantiated per output on the active table and feeding the select_SE registers.

Test Plan:
- Identity: write route[j]=j, en=1 for all 8 outputs, commit -> commit_done at t+10; select_SE[j]=1<<j; out_en=8'hFF; commit_err never pulses.
- Collision (ALLOW_MULTICAST=0): active=identity; shadow route=[3,1,7,0,2,6,3,4], all enabled, commit -> commit_err pulses, collide_dst=6, select_SE unchanged, no commit_done.
- Same table with en[6]=0 -> commit_done; select_SE[6]=0, out_en=8'hBF, select_SE[0]=8'b00001000.
- Multicast (ALLOW_MULTICAST=1): all route[j]=0 enabled, commit -> commit_done at t+3; every select_SE[j]=8'b00000001.
- Range and handshake, N_IN=6: write cfg_src=7 -> cfg_err pulse, shadow unchanged. commit_req and cfg_valid during CHECK -> cfg_ready=0, request ignored, busy=1.
- Reset mid-CHECK: drop rst_n at cycle t+3 -> outputs immediately 0, FSM IDLE. After release, commit of the all-disabled reset table -> commit_done, select_SE all 0.
